// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single memory port, shared by a one-word fetch requester
// and a fixed-length vector burst requester (read or write).
module mem_port_arbiter #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned BURST_LEN = 16
) (
   input  logic             Clk1,
   input  logic             Reset,
   input  logic             F_req,
   input  logic [WIDTH-1:0] F_addr,
   output logic             F_gnt,
   output logic             F_valid,
   output logic [WIDTH-1:0] F_rdata,
   input  logic             V_req,
   input  logic             V_wr,
   input  logic [WIDTH-1:0] V_base,
   input  logic [WIDTH-1:0] V_wdata,
   output logic             V_gnt,
   output logic [3:0]       V_idx,
   output logic             V_valid,
   output logic [WIDTH-1:0] V_rdata,
   output logic [3:0]       V_ridx,
   output logic             V_done,
   output logic [WIDTH-1:0] Addr,
   output logic             RD,
   output logic             WR,
   output logic [WIDTH-1:0] DataOut,
   input  logic [WIDTH-1:0] DataIn
);
   localparam int unsigned      IDX_W     = 4;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, FETCH, BURST, DRAIN} arbStateT;

   arbStateT         state, stateNext;
   logic [IDX_W-1:0] beatCnt, beatCntNext;
   logic [WIDTH-1:0] baseAddr, baseNext;
   logic [WIDTH-1:0] addrNext;
   logic [WIDTH-1:0] doutHold;
   logic             burstWr, burstWrNext;
   logic             vecLast, vecLastNext;
   logic             rdNext, wrNext, doneNext;
   logic             writeBeat;

   // Next-state, grant and next memory-port values
   always_comb begin
      stateNext   = state;
      beatCntNext = beatCnt;
      baseNext    = baseAddr;
      burstWrNext = burstWr;
      vecLastNext = vecLast;
      addrNext    = Addr;
      rdNext      = 1'b0;
      wrNext      = 1'b0;
      doneNext    = 1'b0;
      F_gnt       = 1'b0;
      V_gnt       = 1'b0;
      case (state)
         IDLE: begin
            // vecLast set means the vector owned the port last, so fetch wins a tie
            if (Reset && F_req && (!V_req || vecLast)) begin
               F_gnt       = 1'b1;
               addrNext    = F_addr;
               rdNext      = 1'b1;
               vecLastNext = 1'b0;
               stateNext   = FETCH;
            end else if (Reset && V_req) begin
               V_gnt       = 1'b1;
               baseNext    = V_base;
               burstWrNext = V_wr;
               beatCntNext = '0;
               addrNext    = V_base;
               rdNext      = !V_wr;
               wrNext      = V_wr;
               vecLastNext = 1'b1;
               stateNext   = BURST;
            end
         end
         FETCH: stateNext = DRAIN;
         BURST: begin
            if (beatCnt == LAST_BEAT) begin
               doneNext  = 1'b1;
               stateNext = DRAIN;
            end else begin
               beatCntNext = beatCnt + IDX_W'(1);
               addrNext    = baseAddr + WIDTH'(beatCntNext);
               rdNext      = !burstWr;
               wrNext      = burstWr;
            end
         end
         DRAIN: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         beatCnt  <= '0;
         baseAddr <= '0;
         burstWr  <= 1'b0;
         vecLast  <= 1'b0;
         Addr     <= '0;
         RD       <= 1'b0;
         WR       <= 1'b0;
         V_done   <= 1'b0;
      end else begin
         state    <= stateNext;
         beatCnt  <= beatCntNext;
         baseAddr <= baseNext;
         burstWr  <= burstWrNext;
         vecLast  <= vecLastNext;
         Addr     <= addrNext;
         RD       <= rdNext;
         WR       <= wrNext;
         V_done   <= doneNext;
      end
   end

   // Read returns land one cycle after each RD beat; write data follows V_idx directly
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         F_valid  <= 1'b0;
         V_valid  <= 1'b0;
         V_ridx   <= '0;
         doutHold <= '0;
      end else begin
         F_valid <= RD && (state == FETCH);
         V_valid <= RD && (state == BURST);
         if (RD && (state == BURST)) V_ridx <= beatCnt;
         if (writeBeat) doutHold <= V_wdata;
      end
   end

   assign writeBeat = (state == BURST) && burstWr;
   assign DataOut   = writeBeat ? V_wdata : doutHold;
   assign V_idx     = beatCnt;
   assign F_rdata   = F_valid ? DataIn : '0;
   assign V_rdata   = V_valid ? DataIn : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant-time scoreboard of memory beats, read returns
// and burst completions, driven by a request table plus reset and random sequences.
module tb_mem_port_arbiter;
   localparam int unsigned WIDTH     = 16;
   localparam int unsigned BURST_LEN = 16;
   localparam int          TIMEOUT   = 200;

   logic             Clk1 = 1'b0;
   logic             Reset;
   logic             F_req, V_req, V_wr;
   logic [WIDTH-1:0] F_addr, V_base, V_wdata;
   logic             F_gnt, F_valid, V_gnt, V_valid, V_done, RD, WR;
   logic [WIDTH-1:0] F_rdata, V_rdata, Addr, DataOut;
   logic [WIDTH-1:0] DataIn = 16'hA5A5;
   logic [3:0]       V_idx, V_ridx;
   logic [WIDTH-1:0] wOff = 16'h0000;
   int               cyc = 0;
   int               tests = 0;
   int               fails = 0;

   typedef struct { int cyc; logic rd; logic wr; logic [15:0] addr; logic [15:0] dout; logic [3:0] idx; logic isVec; } beatT;
   typedef struct { int cyc; logic isVec; logic [15:0] data; logic [3:0] idx; } retT;
   typedef struct { logic fReq; logic [15:0] fAddr; logic vReq; logic vWr; logic [15:0] vBase; logic [15:0] wOff; logic expFirstF; } rowT;

   beatT expBeat[$];
   retT  expRet[$];
   int   expDone[$];
   rowT  tbl[8];

   mem_port_arbiter #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
      .Clk1(Clk1), .Reset(Reset),
      .F_req(F_req), .F_addr(F_addr), .F_gnt(F_gnt), .F_valid(F_valid), .F_rdata(F_rdata),
      .V_req(V_req), .V_wr(V_wr), .V_base(V_base), .V_wdata(V_wdata), .V_gnt(V_gnt),
      .V_idx(V_idx), .V_valid(V_valid), .V_rdata(V_rdata), .V_ridx(V_ridx), .V_done(V_done),
      .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
   );

   always #5 Clk1 = ~Clk1;
   always @(posedge Clk1) cyc <= cyc + 1;

   function automatic logic [15:0] memVal(input logic [15:0] a);
      return (a == 16'h0040) ? 16'hBEEF : a;
   endfunction

   // Memory: read data appears the cycle after RD is sampled
   always @(posedge Clk1) if (RD) DataIn <= memVal(Addr);

   assign V_wdata = 16'(V_idx) * 16'd3 + wOff;

   task automatic checkV(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checkV(name, 32'(act), 32'(exp));
   endtask

   task automatic monitorCycle();
      beatT b;
      retT  r;
      int   d;
      if (!Reset) begin
         check1("reset_quiet", RD | WR | F_valid | V_valid | V_done | F_gnt | V_gnt, 1'b0);
         expBeat.delete(); expRet.delete(); expDone.delete();
         return;
      end
      if (F_gnt || V_gnt) begin
         check1("one_grant", F_gnt & V_gnt, 1'b0);
         checkV("grant_while_busy", 32'(expBeat.size() + expRet.size() + expDone.size()), 32'd0);
      end
      if (RD || WR) check1("rd_wr_exclusive", RD & WR, 1'b0);
      if (expBeat.size() > 0 && expBeat[0].cyc <= cyc) begin
         b = expBeat.pop_front();
         checkV("beat_cycle", 32'(cyc), 32'(b.cyc));
         check1("beat_rd", RD, b.rd);
         check1("beat_wr", WR, b.wr);
         checkV("beat_addr", 32'(Addr), 32'(b.addr));
         if (b.wr) checkV("beat_dataout", 32'(DataOut), 32'(b.dout));
         if (b.isVec) checkV("beat_vidx", 32'(V_idx), 32'(b.idx));
      end else if (RD || WR) checkV("unexpected_beat", 32'({RD, WR}), 32'd0);
      if (expRet.size() > 0 && expRet[0].cyc <= cyc) begin
         r = expRet.pop_front();
         check1("ret_fvalid", F_valid, !r.isVec);
         check1("ret_vvalid", V_valid, r.isVec);
         checkV("ret_data", 32'(r.isVec ? V_rdata : F_rdata), 32'(r.data));
         if (r.isVec) checkV("ret_vridx", 32'(V_ridx), 32'(r.idx));
      end else if (F_valid || V_valid) checkV("unexpected_return", 32'({F_valid, V_valid}), 32'd0);
      if (expDone.size() > 0 && expDone[0] <= cyc) begin
         d = expDone.pop_front();
         check1("v_done", V_done, 1'b1);
      end else if (V_done) check1("unexpected_done", V_done, 1'b0);
      if (F_gnt) begin
         expBeat.push_back('{cyc + 1, 1'b1, 1'b0, F_addr, 16'h0, 4'h0, 1'b0});
         expRet.push_back('{cyc + 2, 1'b0, memVal(F_addr), 4'h0});
      end
      if (V_gnt) begin
         for (int k = 0; k < int'(BURST_LEN); k++) begin
            expBeat.push_back('{cyc + 1 + k, !V_wr, V_wr, V_base + 16'(k), 16'(k) * 16'd3 + wOff, 4'(k), 1'b1});
            if (!V_wr) expRet.push_back('{cyc + 2 + k, 1'b1, memVal(V_base + 16'(k)), 4'(k)});
         end
         expDone.push_back(cyc + int'(BURST_LEN) + 1);
      end
   endtask

   task automatic tick();
      @(posedge Clk1); #1;
   endtask

   task automatic waitGrant(output logic gF, output logic gV, output int gc);
      gF = 1'b0; gV = 1'b0; gc = -1;
      for (int n = 0; n < TIMEOUT; n++) begin
         @(negedge Clk1);
         if (F_gnt || V_gnt) begin
            gF = F_gnt; gV = V_gnt; gc = cyc;
            break;
         end
      end
      check1("grant_seen", gF | gV, 1'b1);
   endtask

   task automatic waitIdle();
      for (int n = 0; n < TIMEOUT; n++) begin
         tick();
         if (expBeat.size() == 0 && expRet.size() == 0 && expDone.size() == 0) break;
      end
      checkV("ops_retired", 32'(expBeat.size() + expRet.size() + expDone.size()), 32'd0);
   endtask

   task automatic runRow(input int i, input rowT r);
      logic gF, gV;
      int   g1, g2, c0;
      c0 = cyc;
      F_req = r.fReq; F_addr = r.fAddr; V_req = r.vReq; V_wr = r.vWr; V_base = r.vBase; wOff = r.wOff;
      waitGrant(gF, gV, g1);
      check1($sformatf("row%0d_first_is_fetch", i), gF, r.expFirstF);
      check1($sformatf("row%0d_first_is_vector", i), gV, !r.expFirstF);
      checkV($sformatf("row%0d_grant_cycle", i), 32'(g1), 32'(c0));
      tick();
      if (gF) begin F_req = 1'b0; F_addr = 16'($urandom); end
      if (gV) begin V_req = 1'b0; V_base = 16'($urandom); V_wr = 1'($urandom); end
      if (r.fReq && r.vReq) begin
         waitGrant(gF, gV, g2);
         check1($sformatf("row%0d_second_is_fetch", i), gF, !r.expFirstF);
         checkV($sformatf("row%0d_second_grant_cycle", i), 32'(g2),
                32'(g1 + (r.expFirstF ? 3 : int'(BURST_LEN) + 2)));
         tick();
         F_req = 1'b0; V_req = 1'b0;
      end
      waitIdle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d, expected $finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic gF, gV;
      int   g1, g2, g3, c0;
      Reset = 1'b0; F_req = 1'b0; V_req = 1'b0; V_wr = 1'b0; F_addr = '0; V_base = '0;
      fork
         forever begin
            @(negedge Clk1);
            monitorCycle();
         end
      join_none

      tbl[0] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF8, 16'h0000, 1'b0};
      tbl[3] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1};
      tbl[4] = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h1230, 16'h0500, 1'b1};
      tbl[5] = '{1'b1, 16'h0FFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[6] = '{1'b1, 16'h0030, 1'b1, 1'b0, 16'h7FF8, 16'h0000, 1'b0};
      tbl[7] = '{1'b1, 16'h0050, 1'b1, 1'b1, 16'hFFFF, 16'h1000, 1'b0};

      // Reset values with both requesters already asserting
      repeat (3) @(posedge Clk1);
      #1;
      F_req = 1'b1; F_addr = 16'h0044; V_req = 1'b1; V_wr = 1'b0; V_base = 16'h0300;
      @(negedge Clk1);
      check1("rst_f_gnt", F_gnt, 1'b0);
      check1("rst_v_gnt", V_gnt, 1'b0);
      check1("rst_rd", RD, 1'b0);
      check1("rst_wr", WR, 1'b0);
      check1("rst_v_done", V_done, 1'b0);
      checkV("rst_addr", 32'(Addr), 32'd0);
      checkV("rst_dataout", 32'(DataOut), 32'd0);
      checkV("rst_v_idx", 32'(V_idx), 32'd0);
      checkV("rst_v_ridx", 32'(V_ridx), 32'd0);
      checkV("rst_v_rdata", 32'(V_rdata), 32'd0);
      checkV("rst_f_rdata", 32'(F_rdata), 32'd0);

      // Tie after reset: vector first; vector re-requests, so fetch wins the next tie
      tick();
      Reset = 1'b1; c0 = cyc;
      waitGrant(gF, gV, g1);
      check1("tie1_vector", gV, 1'b1);
      check1("tie1_not_fetch", gF, 1'b0);
      checkV("first_grant_after_reset", 32'(g1), 32'(c0));
      tick();
      V_base = 16'h0400;
      waitGrant(gF, gV, g2);
      check1("tie2_fetch", gF, 1'b1);
      checkV("tie2_cycle", 32'(g2), 32'(g1 + int'(BURST_LEN) + 2));
      tick();
      F_req = 1'b0;
      waitGrant(gF, gV, g3);
      check1("tie3_vector", gV, 1'b1);
      checkV("tie3_cycle", 32'(g3), 32'(g2 + 3));
      tick();
      V_req = 1'b0;
      waitIdle();

      for (int i = 0; i < 8; i++) runRow(i, tbl[i]);

      // Reset during beat 5 of a read burst
      V_req = 1'b1; V_wr = 1'b0; V_base = 16'h2000;
      waitGrant(gF, gV, g1);
      check1("rst_burst_granted", gV, 1'b1);
      tick();
      V_req = 1'b0;
      repeat (5) tick();
      check1("beat5_rd_before_reset", RD, 1'b1);
      checkV("beat5_idx_before_reset", 32'(V_idx), 32'd5);
      Reset = 1'b0;
      #1;
      check1("rd_after_async_reset", RD, 1'b0);
      check1("vvalid_after_async_reset", V_valid, 1'b0);
      checkV("idx_after_async_reset", 32'(V_idx), 32'd0);
      repeat (2) tick();
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk1);
         check1("no_vvalid_after_abandon", V_valid, 1'b0);
         check1("no_vdone_after_abandon", V_done, 1'b0);
      end
      tick();
      c0 = cyc;
      F_req = 1'b1; F_addr = 16'h0040;
      waitGrant(gF, gV, g1);
      check1("post_reset_fetch", gF, 1'b1);
      checkV("post_reset_grant_cycle", 32'(g1), 32'(c0));
      tick();
      F_req = 1'b0;
      waitIdle();

      // Random requesters, held until granted
      for (int i = 0; i < 400; i++) begin
         @(negedge Clk1);
         gF = F_gnt; gV = V_gnt;
         tick();
         if (gF) F_req = 1'b0;
         if (gV) V_req = 1'b0;
         if (!F_req && $urandom_range(0, 3) == 0) begin F_req = 1'b1; F_addr = 16'($urandom); end
         if (!V_req && $urandom_range(0, 7) == 0) begin
            V_req = 1'b1; V_wr = 1'($urandom_range(0, 1)); V_base = 16'($urandom);
         end
      end
      F_req = 1'b0; V_req = 1'b0;
      waitIdle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: WIDTH, 16, data and address width; BURST_LEN, 16, words per vector burst (power of two, 2..16).
REQ-002 Clk1  input  1  sole clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 F_req  input  1  fetch requester wants one word read; level, held until F_gnt.
REQ-005 F_addr  input  WIDTH  fetch address, sampled in the grant cycle.
REQ-006 F_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 F_valid / F_rdata  output  1 / WIDTH  one-cycle pulse with fetched word.
REQ-008 V_req / V_wr / V_base  input  1 / 1 / WIDTH  vector burst request, direction (1 = write), base address; held until V_gnt.
REQ-009 V_wdata  input  WIDTH  write word for the current V_idx; combinationally consumed.
REQ-010 V_gnt  output  1  one-cycle pulse: burst accepted.
REQ-011 V_idx  output  4  element index of the memory beat in progress.
REQ-012 V_valid / V_rdata / V_ridx  output  1 / WIDTH / 4  read-beat return, its data and element index.
REQ-013 V_done  output  1  one-cycle pulse: burst complete.
REQ-014 Addr / RD / WR / DataOut  output  WIDTH / 1 / 1 / WIDTH  memory port.
REQ-015 DataIn  input  WIDTH  memory read data, valid the cycle after RD is sampled.

Function
REQ-016 States: IDLE, FETCH, BURST, DRAIN; exactly one owner of the memory port outside IDLE.
REQ-017 IDLE with only F_req: F_gnt=1, latch F_addr, next FETCH; with only V_req: V_gnt=1, latch V_base and V_wr, beat counter cleared to 0, next BURST.
REQ-018 IDLE with F_req and V_req together: grant the requester not granted last (round-robin flag); flag resets to "fetch last", so vector wins the first tie.
REQ-019 FETCH: RD=1, Addr=latched address, one cycle; next DRAIN.
REQ-020 BURST: Addr=base+counter modulo 2^WIDTH (wraps, no carry out), RD=!V_wr, WR=V_wr, DataOut=V_wdata when writing, V_idx=counter; counter increments each cycle; after beat BURST_LEN-1, next DRAIN.
REQ-021 Read data capture: one cycle after every RD beat, V_valid=1, V_rdata=DataIn, V_ridx=index of that beat (burst) or F_valid=1, F_rdata=DataIn (fetch); exactly BURST_LEN V_valid pulses per read burst, none for writes.
REQ-022 DRAIN: RD=WR=0; final read word returned per REQ-021; V_done=1 if a burst ended; next IDLE.
REQ-023 Minimum spacing: no grant in DRAIN; new grant earliest in the following IDLE cycle; back-to-back requests give 1 idle port cycle (DRAIN) plus 1 grant cycle between operations.
REQ-024 Requests arriving while busy are ignored until IDLE; requester inputs other than V_wdata are don't-care after grant.
REQ-025 RD and WR never both 1; Addr, DataOut hold last value when port idle; RD/WR are 0 in IDLE and DRAIN.
REQ-026 Fetch latency: F_gnt cycle n, RD cycle n+1, F_valid cycle n+2. Burst latency: V_gnt cycle n, beats n+1..n+BURST_LEN, V_done cycle n+BURST_LEN+1.

Reset
REQ-027 Reset low asynchronously forces IDLE, counter 0, round-robin flag "fetch last", and all pulse outputs, RD, WR, F_gnt, V_gnt, V_valid, F_valid, V_done to 0; Addr, DataOut, data outputs, V_idx, V_ridx to 0.
REQ-028 Reset asserted mid-burst or mid-fetch abandons the operation: no further V_valid, F_valid or V_done; requester must re-request after release.
REQ-029 First grant possible on the first rising Clk1 edge after Reset deasserts.

Verification
REQ-030 Single fetch: F_addr=0x0040, memory returns 0xBEEF -> F_gnt, one RD at Addr 0x0040, F_valid with 0xBEEF two cycles after grant.
REQ-031 Read burst: V_base=0x0100, memory word = address -> RD at 0x0100..0x010F, 16 V_valid pulses, V_ridx 0..15, V_rdata 0x0100..0x010F, V_done at grant+17.
REQ-032 Write burst wrap: V_base=0xFFF8, V_wdata=V_idx*3 -> WR at 0xFFF8..0xFFFF then 0x0000..0x0007, DataOut 0,3,...,45, no V_valid.
REQ-033 Simultaneous F_req and V_req after reset -> vector granted first, fetch granted at first IDLE after V_done; repeat tie -> fetch wins.
REQ-034 Reset low at beat 5 of read burst -> RD=0 immediately, no V_valid/V_done afterwards, next request granted normally.
REQ-035 Continuous random requests -> assertion: RD&WR never 1, beats per burst exactly BURST_LEN, no grant in DRAIN.
